// File: rtl/pc_msg_router.sv
// Bus-clock controller between the PC host channel and the application. It splits inbound
// host words into pixel and DRAM-burst streams and arbitrates outbound messages to the host.
module pc_msg_router #(
    parameter int XB_SIZE    = 32,
    parameter int DRAM_BURST = 16
) (
    input  logic               bus_clk,
    input  logic               reset,
    input  logic               pc_msg_empty,
    input  logic [XB_SIZE-1:0] pc_msg,
    output logic               pc_msg_ack,
    input  logic               pix_full,
    output logic               pix_wren,
    output logic [XB_SIZE-1:0] pix_data,
    input  logic               dram_full,
    output logic               dram_wren,
    output logic [XB_SIZE-1:0] dram_data,
    input  logic               err_req,
    input  logic [XB_SIZE-1:0] err_msg,
    output logic               err_ack,
    input  logic               ext_req,
    input  logic [XB_SIZE-1:0] ext_msg,
    output logic               ext_ack,
    input  logic               fpga_msg_full,
    output logic               fpga_msg_valid,
    output logic [XB_SIZE-1:0] fpga_msg,
    output logic               error
);

    localparam int CW = $clog2(DRAM_BURST);

    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
    typedef enum logic {LG_EXT = 1'b0, LG_STAT = 1'b1} last_t;

    state_t             state_q, state_d;
    last_t              last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        pix_cnt_q, pix_cnt_d;
    logic [11:0]        burst_cnt_q, burst_cnt_d;
    logic               stat_pend_q, stat_pend_d;
    logic               error_q, error_d;
    logic               pix_wren_q, pix_wren_d;
    logic [XB_SIZE-1:0] pix_data_q, pix_data_d;
    logic               dram_wren_q, dram_wren_d;
    logic [XB_SIZE-1:0] dram_data_q, dram_data_d;
    logic               valid_q, valid_d;
    logic [XB_SIZE-1:0] fpga_msg_q, fpga_msg_d;
    logic               err_ack_q, err_ack_d;
    logic               ext_ack_q, ext_ack_d;

    logic [1:0]         tag_s;
    logic               stall_s;
    logic               ack_s;
    logic               stat_set_s;
    logic               stat_grant_s;
    logic [XB_SIZE-1:0] status_s;

    assign tag_s    = pc_msg[1:0];
    assign status_s = {pix_cnt_q, burst_cnt_q, state_q == ST_BURST, error_q, 2'b11};

    // Back-pressure: only the FIFO the head word is headed for can stall it.
    always_comb begin
        stall_s = 1'b0;
        if (state_q == ST_BURST) begin
            stall_s = dram_full;
        end else begin
            case (tag_s)
                2'b00:   stall_s = dram_full;
                2'b11:   stall_s = 1'b0;
                default: stall_s = pix_full;
            endcase
        end
    end

    assign ack_s      = !reset && !pc_msg_empty && !error_q && !stall_s;
    assign pc_msg_ack = ack_s;

    // Inbound routing, burst tracking and statistics.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pix_cnt_d   = pix_cnt_q;
        burst_cnt_d = burst_cnt_q;
        pix_wren_d  = 1'b0;
        pix_data_d  = pix_data_q;
        dram_wren_d = 1'b0;
        dram_data_d = dram_data_q;
        stat_set_s  = 1'b0;
        // almost_full rising under a write already in flight means the slack contract broke
        error_d     = error_q | (pix_wren_q & pix_full) | (dram_wren_q & dram_full);
        if (ack_s) begin
            if (state_q == ST_BURST) begin
                dram_wren_d = 1'b1;
                dram_data_d = pc_msg;
                if (cnt_q == CW'(1)) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = burst_cnt_q + 12'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end else begin
                case (tag_s)
                    2'b00: begin
                        dram_wren_d = 1'b1;
                        dram_data_d = pc_msg;
                        cnt_d       = CW'(DRAM_BURST - 1);
                        state_d     = ST_BURST;
                    end
                    2'b11: begin
                        stat_set_s = 1'b1;
                    end
                    default: begin
                        pix_wren_d = 1'b1;
                        pix_data_d = pc_msg;
                        pix_cnt_d  = pix_cnt_q + 16'd1;
                    end
                endcase
            end
        end
    end

    // Outbound arbiter: error first, then status/ext round-robin, one grant per two cycles.
    always_comb begin
        valid_d      = 1'b0;
        err_ack_d    = 1'b0;
        ext_ack_d    = 1'b0;
        fpga_msg_d   = fpga_msg_q;
        last_d       = last_q;
        stat_grant_s = 1'b0;
        if (!fpga_msg_full && !valid_q) begin
            if (err_req) begin
                valid_d    = 1'b1;
                err_ack_d  = 1'b1;
                fpga_msg_d = err_msg;
            end else if (stat_pend_q && (!ext_req || last_q == LG_EXT)) begin
                valid_d      = 1'b1;
                fpga_msg_d   = status_s;
                last_d       = LG_STAT;
                stat_grant_s = 1'b1;
            end else if (ext_req) begin
                valid_d    = 1'b1;
                ext_ack_d  = 1'b1;
                fpga_msg_d = ext_msg;
                last_d     = LG_EXT;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
        // a request landing in the grant cycle is newer than the reply and must be kept
        if (stat_set_s) begin
            stat_pend_d = 1'b1;
        end else if (stat_grant_s) begin
            stat_pend_d = 1'b0;
        end else begin
            stat_pend_d = stat_pend_q;
        end
    end

    // State and output registers.
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= LG_EXT;
            cnt_q       <= '0;
            pix_cnt_q   <= 16'd0;
            burst_cnt_q <= 12'd0;
            stat_pend_q <= 1'b0;
            error_q     <= 1'b0;
            pix_wren_q  <= 1'b0;
            pix_data_q  <= '0;
            dram_wren_q <= 1'b0;
            dram_data_q <= '0;
            valid_q     <= 1'b0;
            fpga_msg_q  <= '0;
            err_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            stat_pend_q <= stat_pend_d;
            error_q     <= error_d;
            pix_wren_q  <= pix_wren_d;
            pix_data_q  <= pix_data_d;
            dram_wren_q <= dram_wren_d;
            dram_data_q <= dram_data_d;
            valid_q     <= valid_d;
            fpga_msg_q  <= fpga_msg_d;
            err_ack_q   <= err_ack_d;
            ext_ack_q   <= ext_ack_d;
        end
    end

    assign pix_wren       = pix_wren_q;
    assign pix_data       = pix_data_q;
    assign dram_wren      = dram_wren_q;
    assign dram_data      = dram_data_q;
    assign fpga_msg_valid = valid_q;
    assign fpga_msg       = fpga_msg_q;
    assign err_ack        = err_ack_q;
    assign ext_ack        = ext_ack_q;
    assign error          = error_q;

endmodule

// File: tb/tb_pc_msg_router.sv
// Directed bench for pc_msg_router: host FIFO model, output logs, per-scenario checks.
module tb_pc_msg_router;

    logic        bus_clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_msg_empty = 1'b1;
    logic [31:0] pc_msg = 32'h0;
    logic        pc_msg_ack;
    logic        pix_full = 1'b0;
    logic        pix_wren;
    logic [31:0] pix_data;
    logic        dram_full = 1'b0;
    logic        dram_wren;
    logic [31:0] dram_data;
    logic        err_req = 1'b0;
    logic [31:0] err_msg = 32'h0;
    logic        err_ack;
    logic        ext_req = 1'b0;
    logic [31:0] ext_msg = 32'h0;
    logic        ext_ack;
    logic        fpga_msg_full = 1'b0;
    logic        fpga_msg_valid;
    logic [31:0] fpga_msg;
    logic        error;

    pc_msg_router #(.XB_SIZE(32), .DRAM_BURST(16)) dut (
        .bus_clk(bus_clk), .reset(reset),
        .pc_msg_empty(pc_msg_empty), .pc_msg(pc_msg), .pc_msg_ack(pc_msg_ack),
        .pix_full(pix_full), .pix_wren(pix_wren), .pix_data(pix_data),
        .dram_full(dram_full), .dram_wren(dram_wren), .dram_data(dram_data),
        .err_req(err_req), .err_msg(err_msg), .err_ack(err_ack),
        .ext_req(ext_req), .ext_msg(ext_msg), .ext_ack(ext_ack),
        .fpga_msg_full(fpga_msg_full), .fpga_msg_valid(fpga_msg_valid),
        .fpga_msg(fpga_msg), .error(error)
    );

    always #5 bus_clk = ~bus_clk;

    int total = 0;
    int bad = 0;
    logic [31:0] host [0:63];
    int wr_idx = 0;
    int rd_idx = 0;
    int cyc = 0;
    logic ack_seen = 1'b0;
    logic [31:0] pix_log[$];
    logic [31:0] dram_log[$];
    logic [31:0] out_log[$];
    int out_src[$];
    int out_cyc[$];

    task automatic push(input logic [31:0] w);
        host[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic clear_logs();
        pix_log.delete(); dram_log.delete(); out_log.delete(); out_src.delete(); out_cyc.delete();
    endtask

    // One bus cycle: present FIFO head, note ack, clock, log registered outputs.
    task automatic step();
        pc_msg_empty = (rd_idx >= wr_idx);
        pc_msg = (rd_idx < wr_idx) ? host[rd_idx] : 32'h0;
        #1;
        ack_seen = pc_msg_ack;
        if (ack_seen) rd_idx++;
        @(posedge bus_clk);
        #2;
        cyc++;
        if (pix_wren) pix_log.push_back(pix_data);
        if (dram_wren) dram_log.push_back(dram_data);
        if (fpga_msg_valid) begin
            out_log.push_back(fpga_msg);
            out_src.push_back(err_ack ? 0 : (ext_ack ? 1 : 2));
            out_cyc.push_back(cyc);
        end
        if (err_ack) err_req = 1'b0;
        if (ext_ack) ext_req = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({pc_msg_ack, pix_wren, dram_wren, fpga_msg_valid, err_ack, ext_ack, error} !== 7'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 0000000",
                {pc_msg_ack, pix_wren, dram_wren, fpga_msg_valid, err_ack, ext_ack, error});
        end
        total++;
        if ({pix_data, dram_data, fpga_msg} !== 96'h0) begin
            bad++; $display("FAIL reset_data: got %h %h %h want 0", pix_data, dram_data, fpga_msg);
        end
        @(posedge bus_clk); #2;
        reset = 1'b0;
        step();
        total++;
        if ({pix_wren, dram_wren, fpga_msg_valid, error} !== 4'b0) begin
            bad++; $display("FAIL idle_after_reset: got %b want 0000", {pix_wren, dram_wren, fpga_msg_valid, error});
        end
    endtask

    task automatic test_pixel();
        clear_logs();
        push(32'h0000_0001);
        push(32'h1234_5672);
        step();
        total++;
        if (ack_seen !== 1'b1 || pix_wren !== 1'b1 || pix_data !== 32'h0000_0001) begin
            bad++; $display("FAIL pixel_first: got ack=%b wren=%b data=%h want 1 1 00000001", ack_seen, pix_wren, pix_data);
        end
        step();
        total++;
        if (ack_seen !== 1'b1 || pix_wren !== 1'b1 || pix_data !== 32'h1234_5672) begin
            bad++; $display("FAIL pixel_second: got ack=%b wren=%b data=%h want 1 1 12345672", ack_seen, pix_wren, pix_data);
        end
        step();
        total++;
        if (ack_seen !== 1'b0 || pix_wren !== 1'b0 || dram_wren !== 1'b0) begin
            bad++; $display("FAIL pixel_idle: got ack=%b pix=%b dram=%b want 0 0 0", ack_seen, pix_wren, dram_wren);
        end
    endtask

    task automatic test_burst();
        logic [31:0] exp_w [0:15];
        clear_logs();
        exp_w[0] = 32'hABCD_0000;
        for (int i = 1; i < 16; i++) exp_w[i] = 32'hB000_0000 | (i << 4) | ((i % 2 == 1) ? 32'h1 : 32'h3);
        for (int i = 0; i < 16; i++) push(exp_w[i]);
        push(32'h5555_0001);
        repeat (24) step();
        total++;
        if (dram_log.size() !== 16) begin
            bad++; $display("FAIL burst_count: got %0d want 16", dram_log.size());
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= dram_log.size() || dram_log[i] !== exp_w[i]) begin
                bad++; $display("FAIL burst_word%0d: got %h want %h", i,
                    (i < dram_log.size()) ? dram_log[i] : 32'hxxxx_xxxx, exp_w[i]);
            end
        end
        total++;
        if (pix_log.size() !== 1 || pix_log[0] !== 32'h5555_0001) begin
            bad++; $display("FAIL burst_then_pixel: got n=%0d first=%h want 1 55550001",
                pix_log.size(), (pix_log.size() > 0) ? pix_log[0] : 32'h0);
        end
        total++;
        if (out_log.size() !== 0) begin
            bad++; $display("FAIL burst_no_status: got %0d outbound want 0", out_log.size());
        end
    endtask

    task automatic test_status();
        clear_logs();
        fpga_msg_full = 1'b1;
        ext_msg = 32'hE0E0_E001;
        ext_req = 1'b1;
        push(32'h0000_0003);
        push(32'h0000_0007);
        step();
        step();
        step();
        total++;
        if (rd_idx !== wr_idx || fpga_msg_valid !== 1'b0) begin
            bad++; $display("FAIL status_hold: got left=%0d valid=%b want 0 0", wr_idx - rd_idx, fpga_msg_valid);
        end
        fpga_msg_full = 1'b0;
        repeat (10) step();
        total++;
        if (out_log.size() !== 2) begin
            bad++; $display("FAIL status_count: got %0d want 2", out_log.size());
        end
        total++;
        if (out_log.size() < 2 || out_src[0] !== 2 || out_log[0] !== 32'h0003_0013) begin
            bad++; $display("FAIL status_reply: got src=%0d msg=%h want 2 00030013",
                (out_src.size() > 0) ? out_src[0] : -1, (out_log.size() > 0) ? out_log[0] : 32'h0);
        end
        total++;
        if (out_log.size() < 2 || out_src[1] !== 1 || out_log[1] !== 32'hE0E0_E001
            || (out_cyc[1] - out_cyc[0]) < 2) begin
            bad++; $display("FAIL status_then_ext: got n=%0d want ext E0E0E001 >=2 cycles later", out_log.size());
        end
    endtask

    task automatic test_dram_stall();
        logic [31:0] exp_w [0:15];
        clear_logs();
        exp_w[0] = 32'h0000_0100;
        for (int i = 1; i < 16; i++) exp_w[i] = 32'hC000_0000 | (i << 4) | (i % 3 + 1);
        for (int i = 0; i < 6; i++) push(exp_w[i]);
        repeat (8) step();
        for (int i = 6; i < 16; i++) push(exp_w[i]);
        dram_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (ack_seen !== 1'b0 || dram_wren !== 1'b0) begin
                bad++; $display("FAIL stall_cycle%0d: got ack=%b wren=%b want 0 0", k, ack_seen, dram_wren);
            end
        end
        dram_full = 1'b0;
        repeat (14) step();
        total++;
        if (dram_log.size() !== 16 || error !== 1'b0) begin
            bad++; $display("FAIL stall_total: got n=%0d error=%b want 16 0", dram_log.size(), error);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= dram_log.size() || dram_log[i] !== exp_w[i]) begin
                bad++; $display("FAIL stall_word%0d: got %h want %h", i,
                    (i < dram_log.size()) ? dram_log[i] : 32'hxxxx_xxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_err_ext();
        clear_logs();
        fpga_msg_full = 1'b1;
        err_msg = 32'hDEAD_0001;
        err_req = 1'b1;
        ext_msg = 32'hE0E0_0002;
        ext_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (fpga_msg_valid !== 1'b0) begin
                bad++; $display("FAIL full_block%0d: got valid=%b want 0", k, fpga_msg_valid);
            end
        end
        fpga_msg_full = 1'b0;
        repeat (8) step();
        total++;
        if (out_log.size() !== 2 || out_src[0] !== 0 || out_log[0] !== 32'hDEAD_0001) begin
            bad++; $display("FAIL err_first: got n=%0d msg=%h want 2 DEAD0001",
                out_log.size(), (out_log.size() > 0) ? out_log[0] : 32'h0);
        end
        total++;
        if (out_log.size() < 2 || out_src[1] !== 1 || out_log[1] !== 32'hE0E0_0002) begin
            bad++; $display("FAIL ext_second: got msg=%h want E0E00002",
                (out_log.size() > 1) ? out_log[1] : 32'h0);
        end
    endtask

    task automatic test_error();
        clear_logs();
        push(32'h0000_0011);
        push(32'h0000_0022);
        push(32'h0000_0031);
        step();
        total++;
        if (pix_wren !== 1'b1 || pix_data !== 32'h0000_0011) begin
            bad++; $display("FAIL err_setup: got wren=%b data=%h want 1 00000011", pix_wren, pix_data);
        end
        pix_full = 1'b1;
        step();
        total++;
        if (error !== 1'b1) begin
            bad++; $display("FAIL err_set: got %b want 1", error);
        end
        pix_full = 1'b0;
        step();
        total++;
        if (ack_seen !== 1'b0 || error !== 1'b1 || pix_wren !== 1'b0) begin
            bad++; $display("FAIL err_stuck: got ack=%b error=%b wren=%b want 0 1 0", ack_seen, error, pix_wren);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({pc_msg_ack, pix_wren, dram_wren, fpga_msg_valid, err_ack, ext_ack, error} !== 7'b0
            || pix_data !== 32'h0) begin
            bad++; $display("FAIL err_reset: got %b pix_data=%h want 0000000 0",
                {pc_msg_ack, pix_wren, dram_wren, fpga_msg_valid, err_ack, ext_ack, error}, pix_data);
        end
        @(posedge bus_clk); #2;
        reset = 1'b0;
        step();
        total++;
        if (ack_seen !== 1'b1 || pix_wren !== 1'b1 || pix_data !== 32'h0000_0022) begin
            bad++; $display("FAIL err_resume: got ack=%b wren=%b data=%h want 1 1 00000022", ack_seen, pix_wren, pix_data);
        end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_burst();
        test_status();
        test_dram_stall();
        test_err_ext();
        test_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
